// File: rtl/doodle_x_motion.sv
// Horizontal motion controller for the doodle sprite: joystick level decode, velocity ramp,
// position integration with border clamping. Define DOODLE_X_WRAP_EN to wrap at the borders instead.
module doodle_x_motion #(
   parameter int POS_W      = 10,
   parameter int X_W        = 10,
   parameter int VEL_W      = 6,
   parameter int CENTER     = 512,
   parameter int DEADZONE   = 75,
   parameter int ZONE_STEP  = 200,
   parameter int NUM_LEVELS = 2,
   parameter int SPEED_STEP = 1,
   parameter int ACCEL      = 1,
   parameter int HBP        = 325,
   parameter int HFP        = 625,
   parameter int SIZE       = 20,
   parameter int X_START    = 450
) (
   input  logic             doodle_clk,
   input  logic             rst,
   input  logic [POS_W-1:0] posData,
   input  logic             freeze,
   input  logic             respawn,
   input  logic [X_W-1:0]   load_x,
   output logic [X_W-1:0]   d_x,
   output logic [VEL_W-1:0] vel,
   output logic [2:0]       state,
   output logic             at_wall,
   output logic [7:0]       Led
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEL  = 3'd1,
      S_CRUISE = 3'd2,
      S_DECEL  = 3'd3,
      S_WALL   = 3'd4
   } state_e;

   localparam int SW = X_W + 2;
   localparam int XR = HFP - SIZE;
   localparam logic signed [SW-1:0]  XR_S  = SW'(XR);
   localparam logic signed [SW-1:0]  XL_S  = SW'(HBP);
   localparam logic signed [VEL_W:0] ACC_S = (VEL_W+1)'(ACCEL);

   state_e                  state_q, state_d;
   logic [X_W-1:0]          d_x_q, d_x_d;
   logic signed [VEL_W-1:0] vel_q, vel_d;
   logic                    at_wall_q, at_wall_d;
   logic [1:0]              lvl_r_q, lvl_r_d, lvl_l_q, lvl_l_d;

   logic signed [POS_W:0]   dev;
   logic [POS_W:0]          mag;
   int unsigned             level;
   logic [1:0]              lvl_sat;
   logic signed [VEL_W-1:0] target;
   logic signed [VEL_W:0]   vdiff;
   logic signed [VEL_W-1:0] vel_ramp;
   logic signed [SW-1:0]    sum;
   logic                    wall;

   function automatic state_e classify(input logic signed [VEL_W-1:0] v,
                                       input logic signed [VEL_W-1:0] t,
                                       input logic w);
      int vi, ti, va, ta;
      vi = int'(v);
      ti = int'(t);
      va = (vi < 0) ? -vi : vi;
      ta = (ti < 0) ? -ti : ti;
      if (w)                       return S_WALL;
      if (vi == 0 && ti == 0)      return S_IDLE;
      if (vi == ti)                return S_CRUISE;
      if (vi == 0)                 return S_ACCEL;
      if (ti != 0 && ((vi < 0) == (ti < 0)) && va < ta) return S_ACCEL;
      return S_DECEL;
   endfunction

   // Joystick decode and velocity ramp towards the selected target speed.
   always_comb begin
      dev = $signed((POS_W+1)'(CENTER)) - $signed({1'b0, posData});
      mag = dev[POS_W] ? $unsigned(-dev) : $unsigned(dev);
      level = 0;
      for (int unsigned k = 1; k <= NUM_LEVELS; k++) begin
         if (int'(mag) > DEADZONE + (int'(k) - 1) * ZONE_STEP) level = k;
      end
      target  = dev[POS_W] ? -VEL_W'(level * SPEED_STEP) : VEL_W'(level * SPEED_STEP);
      lvl_sat = (level > 3) ? 2'd3 : 2'(level);
      lvl_r_d = dev[POS_W] ? 2'd0 : lvl_sat;
      lvl_l_d = dev[POS_W] ? lvl_sat : 2'd0;
      vdiff   = $signed({target[VEL_W-1], target}) - $signed({vel_q[VEL_W-1], vel_q});
      if (vdiff > ACC_S)        vel_ramp = vel_q + VEL_W'(ACCEL);
      else if (vdiff < -ACC_S)  vel_ramp = vel_q - VEL_W'(ACCEL);
      else                      vel_ramp = target;
      sum = $signed({2'b00, d_x_q}) + $signed({{(SW-VEL_W){vel_q[VEL_W-1]}}, vel_q});
   end

   always_ff @(posedge doodle_clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         d_x_q     <= X_W'(X_START);
         vel_q     <= '0;
         at_wall_q <= 1'b0;
         lvl_r_q   <= '0;
         lvl_l_q   <= '0;
      end else begin
         state_q   <= state_d;
         d_x_q     <= d_x_d;
         vel_q     <= vel_d;
         at_wall_q <= at_wall_d;
         lvl_r_q   <= lvl_r_d;
         lvl_l_q   <= lvl_l_d;
      end
   end

   always_comb begin
      d_x_d   = d_x_q;
      vel_d   = vel_q;
      state_d = state_q;
      wall    = 1'b0;
      if (respawn) begin
         d_x_d   = load_x;
         vel_d   = '0;
         state_d = S_IDLE;
      end else if (freeze) begin
         vel_d   = '0;
         state_d = S_IDLE;
      end else begin
         // Position moves by the registered velocity; the ramp only affects the next tick.
         vel_d = (state_q == S_WALL) ? '0 : vel_ramp;
         d_x_d = X_W'(sum);
`ifdef DOODLE_X_WRAP_EN
         if (sum > XR_S)      d_x_d = X_W'(XL_S + (sum - XR_S - 1));
         else if (sum < XL_S) d_x_d = X_W'(XR_S - (XL_S - sum - 1));
`else
         if (sum > XR_S) begin
            d_x_d = X_W'(XR);
            vel_d = '0;
            wall  = 1'b1;
         end else if (sum < XL_S) begin
            d_x_d = X_W'(HBP);
            vel_d = '0;
            wall  = 1'b1;
         end
         if ((d_x_d == X_W'(XR) && target > 0) || (d_x_d == X_W'(HBP) && target < 0))
            wall = 1'b1;
`endif
         state_d = classify(vel_d, target, wall);
         if (state_d == S_WALL) vel_d = '0;
      end
      at_wall_d = (state_d == S_WALL);
   end

   always_comb begin
      d_x     = d_x_q;
      vel     = vel_q;
      state   = state_q;
      at_wall = at_wall_q;
      Led     = {at_wall_q, state_q, lvl_l_q, lvl_r_q};
   end

endmodule

// File: tb/tb_doodle_x_motion.sv
// Scoreboard bench for doodle_x_motion: a per-tick reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_doodle_x_motion;

   localparam int CENTER = 512, DEADZONE = 75, ZONE_STEP = 200, NUM_LEVELS = 2;
   localparam int SPEED_STEP = 1, ACCEL = 1, HBP = 325, HFP = 625, SIZE = 20, X_START = 450;
   localparam int XR = HFP - SIZE;

   logic       doodle_clk = 1'b0;
   logic       rst = 1'b1, freeze = 1'b0, respawn = 1'b0;
   logic [9:0] posData = 10'd512, load_x = 10'd0;
   logic [9:0] d_x;
   logic [5:0] vel;
   logic [2:0] state;
   logic       at_wall;
   logic [7:0] Led;

   always #5 doodle_clk = ~doodle_clk;

   doodle_x_motion #(
      .POS_W(10), .X_W(10), .VEL_W(6), .CENTER(CENTER), .DEADZONE(DEADZONE),
      .ZONE_STEP(ZONE_STEP), .NUM_LEVELS(NUM_LEVELS), .SPEED_STEP(SPEED_STEP),
      .ACCEL(ACCEL), .HBP(HBP), .HFP(HFP), .SIZE(SIZE), .X_START(X_START)
   ) dut (
      .doodle_clk(doodle_clk), .rst(rst), .posData(posData), .freeze(freeze),
      .respawn(respawn), .load_x(load_x), .d_x(d_x), .vel(vel), .state(state),
      .at_wall(at_wall), .Led(Led)
   );

   typedef struct { int x; int v; int st; int w; int led; } exp_t;
   exp_t exp_q[$];
   int n_checks = 0, n_pass = 0;
   int mx = X_START, mv = 0, mst = 0, mwall = 0;

   function automatic void chk(string name, int act, int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, want);
   endfunction

   task automatic model_step(input bit r, input bit rs, input bit fz, input int p, input int ld);
      int dev, mag, lvl, tgt, lr, ll, nv, nx, sum, step, ns;
      bit wall;
      exp_t e;
      dev = CENTER - p;
      mag = (dev < 0) ? -dev : dev;
      lvl = 0;
      if (mag > DEADZONE) begin
         lvl = (mag - DEADZONE - 1) / ZONE_STEP + 1;
         if (lvl > NUM_LEVELS) lvl = NUM_LEVELS;
      end
      tgt = ((dev < 0) ? -lvl : lvl) * SPEED_STEP;
      lr  = (dev > 0) ? ((lvl > 3) ? 3 : lvl) : 0;
      ll  = (dev < 0) ? ((lvl > 3) ? 3 : lvl) : 0;
      if (r) begin
         mx = X_START; mv = 0; mst = 0; mwall = 0; lr = 0; ll = 0;
      end else if (rs) begin
         mx = ld; mv = 0; mst = 0; mwall = 0;
      end else if (fz) begin
         mv = 0; mst = 0; mwall = 0;
      end else begin
         step = tgt - mv;
         if (step > ACCEL) step = ACCEL;
         if (step < -ACCEL) step = -ACCEL;
         nv   = (mst == 4) ? 0 : mv + step;
         sum  = mx + mv;
         nx   = sum;
         wall = 1'b0;
`ifdef DOODLE_X_WRAP_EN
         if (sum > XR) nx = HBP + (sum - XR - 1);
         else if (sum < HBP) nx = XR - (HBP - sum - 1);
`else
         if (sum > XR) begin nx = XR; wall = 1'b1; end
         else if (sum < HBP) begin nx = HBP; wall = 1'b1; end
         if ((nx == XR && tgt > 0) || (nx == HBP && tgt < 0)) wall = 1'b1;
`endif
         if (wall) begin ns = 4; nv = 0; end
         else if (nv == 0 && tgt == 0) ns = 0;
         else if (nv == tgt) ns = 2;
         else if (nv == 0 || (nv * tgt > 0 && nv * nv < tgt * tgt)) ns = 1;
         else ns = 3;
         mx = nx; mv = nv; mst = ns; mwall = (ns == 4) ? 1 : 0;
      end
      e.x = mx; e.v = mv; e.st = mst; e.w = mwall;
      e.led = mwall * 128 + mst * 16 + ll * 4 + lr;
      exp_q.push_back(e);
   endtask

   task automatic tick(input bit r, input bit rs, input bit fz, input int p, input int ld);
      @(negedge doodle_clk);
      rst = r; respawn = rs; freeze = fz; posData = 10'(p); load_x = 10'(ld);
      @(posedge doodle_clk);
      model_step(r, rs, fz, p, ld);
   endtask

   always @(negedge doodle_clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("d_x", int'(d_x), e.x);
         chk("vel", int'($signed(vel)), e.v);
         chk("state", int'(state), e.st);
         chk("at_wall", int'(at_wall), e.w);
         chk("Led", int'(Led), e.led);
      end
   end

   initial begin
      int bounds[8];
      int p, n;
      bit fz, rs, r;
      bounds = '{436, 437, 236, 237, 588, 587, 788, 787};
      repeat (2) tick(1, 0, 0, 512, 0);
      repeat (10) tick(0, 0, 0, 512, 0);
      repeat (6) tick(0, 0, 0, 100, 0);
      repeat (6) tick(0, 0, 0, 900, 0);
      tick(0, 1, 0, 512, 600);
      repeat (8) tick(0, 0, 0, 100, 0);
      repeat (3) tick(0, 0, 0, 512, 0);
      repeat (4) tick(0, 0, 0, 100, 0);
      repeat (3) tick(0, 0, 1, 100, 0);
      tick(1, 1, 1, 100, 600);
      repeat (4) tick(0, 0, 0, 100, 0);
      tick(0, 1, 0, 900, 340);
      repeat (20) tick(0, 0, 0, 900, 0);
      repeat (3) tick(0, 0, 0, 100, 0);
      foreach (bounds[i]) repeat (2) tick(0, 0, 0, bounds[i], 0);
      for (int s = 0; s < 300; s++) begin
         p = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 1023)
                                         : int'($urandom_range(0, 1023));
         n = $urandom_range(1, 12);
         for (int t = 0; t < n; t++) begin
            r  = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 49) == 0);
            fz = ($urandom_range(0, 29) == 0);
            tick(r, rs, fz, p, $urandom_range(280, 680));
         end
      end
      repeat (3) @(negedge doodle_clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
